// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Byte-addressable data memory with a valid/ready request/response
// handshake. The number of wait states is set by LATENCY. Byte, half and
// word accesses are supported, and loads are sign- or zero-extended.
// Misaligned requests and the reserved size encoding both return an error
// response, and an erroring request never writes memory. Only one request
// is ever outstanding.
//
// Parameters:
//   ADDR_WIDTH - byte-address width; depth is 2^(ADDR_WIDTH-2) 32-bit words
//   LATENCY    - wait-state cycles between accept and access (0..15)
//   INIT_ZERO  - 1: every word starts at 0
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_valid / req_ready      - request handshake
//   req_write                  - 1 = store, 0 = load
//   req_size                   - 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned               - loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata        - byte address, right-aligned store data
//   resp_valid / resp_ready    - response handshake
//   resp_rdata                 - extended load data (0 for stores/errors)
//   resp_error                 - misaligned or reserved-size request
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 0,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int          DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0]  CNT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for a half access with addr[0] set, a word access that is not
    // word-aligned, or the reserved size encoding.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Shift the addressed lane down to bit 0, then extend it. For an aligned
    // half, lane*8 equals addr[1]*16, so one shift serves both sizes.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{16{~uns & shifted[15]}}, shifted[15:0]};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Byte-enable mask for a store of the given size at the given lane.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001 << lane;
            2'b01:   mask = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Replicate the right-aligned store data across every lane so that the
    // byte-enable mask alone picks the destination.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            2'b10:   d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    logic [31:0] mem_r [DEPTH] = '{default: INIT_WORD};

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic [31:0]             resp_rdata_r;
    logic                    resp_error_r;
    logic                    lat_write_r;
    logic [1:0]              lat_size_r;
    logic                    lat_unsigned_r;
    logic [ADDR_WIDTH-1:0]   lat_addr_r;
    logic [31:0]             lat_wdata_r;

    logic                    op_write_s;
    logic [1:0]              op_size_s;
    logic                    op_unsigned_s;
    logic [ADDR_WIDTH-1:0]   op_addr_s;
    logic [31:0]             op_wdata_s;
    logic [ADDR_WIDTH-3:0]   word_idx_s;
    logic [1:0]              lane_s;
    logic [31:0]             rd_word_s;
    logic                    err_s;
    logic [31:0]             rdata_s;
    logic [3:0]              be_s;
    logic [31:0]             sdata_s;
    logic [31:0]             merged_s;
    logic                    do_access_s;
    logic                    we_s;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_error = resp_error_r;

    // Choose the operand source. With zero latency the access happens on the
    // accept edge itself, so live inputs are used while IDLE. Otherwise the
    // latched copy is used.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_write_s    = req_write;
            op_size_s     = req_size;
            op_unsigned_s = req_unsigned;
            op_addr_s     = req_addr;
            op_wdata_s    = req_wdata;
        end else begin
            op_write_s    = lat_write_r;
            op_size_s     = lat_size_r;
            op_unsigned_s = lat_unsigned_r;
            op_addr_s     = lat_addr_r;
            op_wdata_s    = lat_wdata_r;
        end
    end

    // Decode the access and build the load result and the merged store word.
    always_comb begin
        word_idx_s = op_addr_s[ADDR_WIDTH-1:2];
        lane_s     = op_addr_s[1:0];
        rd_word_s  = mem_r[word_idx_s];
        err_s      = access_error(op_size_s, lane_s);
        be_s       = store_mask(op_size_s, lane_s);
        sdata_s    = store_data(op_size_s, op_wdata_s);
        if (op_write_s || err_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            rdata_s = load_extend(rd_word_s, op_size_s, lane_s, op_unsigned_s);
        end
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = be_s[i] ? sdata_s[8*i +: 8] : rd_word_s[8*i +: 8];
        end
    end

    // The access edge is the accept edge when LATENCY is 0. Otherwise it is
    // the WAIT edge where the counter is 0. Reset suppresses the access.
    always_comb begin
        if (reset) begin
            do_access_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: do_access_s = req_valid & req_ready_r & (LATENCY == 0);
                ST_WAIT: do_access_s = (cnt_r == 4'd0);
                default: do_access_s = 1'b0;
            endcase
        end
        we_s = do_access_s & op_write_s & ~err_s;
    end

    // Storage write port. Memory contents are not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 4'd0;
            req_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= 32'h0000_0000;
            resp_error_r   <= 1'b0;
            lat_write_r    <= 1'b0;
            lat_size_r     <= 2'b00;
            lat_unsigned_r <= 1'b0;
            lat_addr_r     <= '0;
            lat_wdata_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        lat_write_r    <= req_write;
                        lat_size_r     <= req_size;
                        lat_unsigned_r <= req_unsigned;
                        lat_addr_r     <= req_addr;
                        lat_wdata_r    <= req_wdata;
                        req_ready_r    <= 1'b0;
                        if (LATENCY == 0) begin
                            resp_rdata_r <= rdata_s;
                            resp_error_r <= err_s;
                            resp_valid_r <= 1'b1;
                            state_r      <= ST_RESP;
                        end else begin
                            cnt_r   <= CNT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        resp_rdata_r <= rdata_s;
                        resp_error_r <= err_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl: one instance with LATENCY=0, one with LATENCY=3.
// A byte-array reference model supplies the expected values.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst0, rst3, sel;
    logic        req_valid, req_write, req_unsigned, resp_ready;
    logic [1:0]  req_size;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;

    logic        rr0, rv0, re0, rr3, rv3, re3;
    logic [31:0] rd0, rd3;
    logic        req_ready_m, resp_valid_m, resp_error_m;
    logic [31:0] resp_rdata_m;

    int tests = 0;
    int fails = 0;

    logic [7:0] mm [2][512];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_WIDTH(9), .LATENCY(0), .INIT_ZERO(1'b1)) dut0 (
        .clk(clk), .reset(rst0),
        .req_valid(req_valid & ~sel), .req_ready(rr0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready & ~sel),
        .resp_rdata(rd0), .resp_error(re0)
    );

    data_memory_ctrl #(.ADDR_WIDTH(9), .LATENCY(3), .INIT_ZERO(1'b1)) dut3 (
        .clk(clk), .reset(rst3),
        .req_valid(req_valid & sel), .req_ready(rr3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_ready(resp_ready & sel),
        .resp_rdata(rd3), .resp_error(re3)
    );

    assign req_ready_m  = sel ? rr3 : rr0;
    assign resp_valid_m = sel ? rv3 : rv0;
    assign resp_rdata_m = sel ? rd3 : rd0;
    assign resp_error_m = sel ? re3 : re0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, computed from the access rules.
    task automatic model_access(input int s, input logic w, input logic [1:0] sz, input logic u,
                                input logic [8:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd = 32'h0;
        if (!er) begin
            n = 1 << sz;
            if (w) begin
                for (int i = 0; i < n; i++) mm[s][9'(a + i)] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mm[s][9'(a + i)]) << (8*i));
                if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endtask

    // Present a request, wait for it to be accepted, then scramble the inputs.
    task automatic accept_req(input logic w, input logic [1:0] sz, input logic u,
                              input logic [8:0] a, input logic [31:0] wd);
        int n = 0;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready_m !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_accept", 32'(req_ready_m), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 9'($urandom); req_wdata = $urandom;
    endtask

    // Run one full transaction and check its latency and the handshake return.
    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                       input logic [8:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int lat = 0;
        accept_req(w, sz, u, a, wd);
        while (resp_valid_m !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), sel ? 32'd3 : 32'd0);
        rd = resp_rdata_m;
        er = resp_error_m;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_after_handshake", 32'(resp_valid_m), 32'd0);
        chk("req_ready_after_handshake", 32'(req_ready_m), 32'd1);
    endtask

    task automatic rand_txns(input int count);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        logic        w, u;
        logic [1:0]  sz;
        logic [8:0]  a;
        logic [31:0] wd;
        for (int k = 0; k < count; k++) begin
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 63));
            wd = $urandom;
            model_access(sel ? 1 : 0, w, sz, u, a, wd, exp_rd, exp_er);
            txn(w, sz, u, a, wd, rd, er);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_error", 32'(er), 32'(exp_er));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 512; i++) mm[s][i] = 8'h00;

        rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 9'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("reset_req_ready", 32'(req_ready_m), 32'd1);
            chk("reset_resp_valid", 32'(resp_valid_m), 32'd0);
            chk("reset_resp_rdata", resp_rdata_m, 32'd0);
            chk("reset_resp_error", 32'(resp_error_m), 32'd0);
        end
        sel = 1'b0;
        rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on the LATENCY=0 instance.
        vecs.push_back('{1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 9'h012, 32'h0000007F, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        32'hDE7FBEEF, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 9'h013, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 9'h013, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 9'h012, 32'h0,        32'hFFFFDE7F, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 9'h012, 32'h0,        32'h0000DE7F, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 9'h011, 32'h11111111, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 9'h005, 32'h0,        32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 9'h010, 32'h22222222, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 9'h010, 32'h0,        32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        32'hDE7FBEEF, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 9'h016, 32'hFFFF1234, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 9'h014, 32'h0,        32'h12340000, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 9'h1FF, 32'h00000080, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 9'h1FF, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0,        32'h80000000, 1'b0});
        foreach (vecs[k]) begin
            model_access(0, vecs[k].w, vecs[k].sz, vecs[k].u, vecs[k].a, vecs[k].wd, exp_rd, exp_er);
            txn(vecs[k].w, vecs[k].sz, vecs[k].u, vecs[k].a, vecs[k].wd, rd, er);
            chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
            chk($sformatf("vec%0d_error", k), 32'(er), 32'(vecs[k].exp_er));
        end

        rand_txns(200);

        // LATENCY=3: check wait states, a stalled response, and ignored requests.
        sel = 1'b1;
        model_access(1, 1'b1, 2'd2, 1'b0, 9'h010, 32'hCAFEF00D, exp_rd, exp_er);
        txn(1'b1, 2'd2, 1'b0, 9'h010, 32'hCAFEF00D, rd, er);
        chk("l3_sw_error", 32'(er), 32'd0);
        accept_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        for (int e = 0; e < 3; e++) begin
            chk($sformatf("l3_wait%0d_req_ready", e), 32'(req_ready_m), 32'd0);
            chk($sformatf("l3_wait%0d_resp_valid", e), 32'(resp_valid_m), 32'd0);
            @(posedge clk); #1;
        end
        chk("l3_resp_valid", 32'(resp_valid_m), 32'd1);
        chk("l3_resp_req_ready", 32'(req_ready_m), 32'd0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 9'h010; req_wdata = 32'h0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_resp_valid", e), 32'(resp_valid_m), 32'd1);
            chk($sformatf("stall%0d_rdata", e), resp_rdata_m, 32'hCAFEF00D);
            chk($sformatf("stall%0d_req_ready", e), 32'(req_ready_m), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("stall_release_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("stall_release_req_ready", 32'(req_ready_m), 32'd1);
        model_access(1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0, exp_rd, exp_er);
        txn(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, rd, er);
        chk("ignored_store_no_effect", rd, exp_rd);

        // A reset during WAIT discards the pending store.
        accept_req(1'b1, 2'd2, 1'b0, 9'h020, 32'h12345678);
        @(posedge clk); #2;
        rst3 = 1'b1;
        #1;
        chk("rst_wait_req_ready", 32'(req_ready_m), 32'd1);
        chk("rst_wait_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("rst_wait_rdata", resp_rdata_m, 32'd0);
        chk("rst_wait_error", 32'(resp_error_m), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        model_access(1, 1'b0, 2'd2, 1'b0, 9'h020, 32'h0, exp_rd, exp_er);
        txn(1'b0, 2'd2, 1'b0, 9'h020, 32'h0, rd, er);
        chk("rst_wait_no_write", rd, exp_rd);
        chk("rst_wait_no_write_val", rd, 32'h0);

        // A reset during RESP drops the response, and memory is unaffected.
        accept_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_pre_valid", 32'(resp_valid_m), 32'd1);
        #2;
        rst3 = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("rst_resp_rdata", resp_rdata_m, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        txn(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, rd, er);
        chk("rst_resp_mem_kept", rd, 32'hCAFEF00D);

        rand_txns(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised byte-addressable data memory for the processor datapath. Successor to the flat 128x32 word memory.
- Adds a valid/ready request/response handshake, configurable access latency (wait states), and byte/half/word sizes with sign or zero extension.
- Detects misaligned and reserved-size accesses.
- Sits between the execute/memory stage and storage, so multi-cycle and stalling memory models can be exercised.

Parameters:
- ADDR_WIDTH, 9: byte-address width. Depth is 2^(ADDR_WIDTH-2) 32-bit words, so the default is 128 words.
- LATENCY, 0: wait-state cycles between request acceptance and the memory access (0..15).
- INIT_ZERO, 1: when 1, every word is initialised to 0 at time zero.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-aligned (low bits used for byte/half)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes the response
- resp_rdata  output  32  extended load data; 0 for stores and on error
- resp_error  output  1  misaligned or reserved-size request

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, wait counter = 0.
  - Reset does not alter memory contents.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid && req_ready, latch write, size, unsigned, addr and wdata.
    - If LATENCY = 0: perform the access on the same edge and go to RESP.
    - Otherwise: load counter = LATENCY-1 and go to WAIT.
  - WAIT: req_ready = 0. Counter decrements each cycle. On the edge where counter == 0, perform the access and go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_error are held stable. On resp_ready, go to IDLE.
    - No request is accepted in RESP, so at most one request is ever outstanding.
    - resp_valid falls one cycle after the handshake.
- Latency: for a request accepted at edge t, resp_valid is visible from edge t+LATENCY onward. Back-to-back throughput with resp_ready tied to 1 is one request per LATENCY+2 cycles.
- Addressing: word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
- Alignment rules:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 00.
  - Size 11 is always an error.
- Error handling: resp_error = 1, resp_rdata = 0, and no memory write occurs.
- Loads:
  - Byte: select bits [8*lane+7 : 8*lane].
  - Half: select bits [16*addr[1]+15 : 16*addr[1]].
  - Extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Stores: write only the addressed byte lanes, taking data from req_wdata[7:0] or [15:0] replicated into the lane. Other bytes of the word are preserved.
  - resp_rdata = 0 and resp_error = 0 on success.
- Input timing: inputs are sampled only at the accept edge. Changes to req_* while in WAIT/RESP have no effect.
- Reset mid-operation: reset asserted in WAIT discards the request with no write. Reset asserted in RESP drops the response. Memory keeps any completed write.
- Address range: the top address wraps naturally, since the full ADDR_WIDTH range maps onto memory.

Test Plan:
- LATENCY=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata 0xDEADBEEF, resp_error 0, resp_valid one cycle after each accept.
- Byte lanes: after the SW above, SB 0x7F @0x12, then LW @0x10 -> 0xDE7FBEEF. LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE. LH @0x12 -> 0xFFFFDE7F. LHU @0x12 -> 0x0000DE7F.
- Misalignment: SW @0x11, LH @0x05, and size 11 -> resp_error 1, resp_rdata 0. A subsequent LW of the affected word is unchanged.
- LATENCY=3: accept at edge t -> req_ready 0 for edges t..t+3. Holding resp_ready 0 for 5 cycles keeps resp_valid and the data stable, and req_valid is ignored. resp_ready then returns the FSM to IDLE.
- Reset: SW 0x12345678 @0x20 with LATENCY=3, then pulse reset during WAIT -> outputs go to reset values immediately, and a later LW @0x20 returns the prior value (0 after init).
